// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan decoder: FSM state encoding and mode input encoding.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Scan-step prescaler: counts 0..PRESCALE-1 while run is high; tick flags the
// terminal-count cycle so the caller can step on that edge.
module scan_prescaler #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
   end

   assign tick = run && (cnt == TERM);

endmodule

// File: rtl/scan_decoder.sv
// Active-low one-hot decoder with manual-load and auto-scan index sources.
// Optional macro SCAN_DECODER_BLANK_EN inserts one all-ones cycle on every index change.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W    = 3,
   parameter int PRESCALE = 50000,
   localparam int OUT_N   = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [SEL_W-1:0] sel_in,
   output logic [OUT_N-1:0] out_n,
   output logic [SEL_W-1:0] sel_cur,
   output logic             tick
);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [OUT_N-1:0] out_nxt, dec;
   logic             sel_load, step, run, clr;

   // Prescaler only advances while staying in SCAN; en=0 on the terminal cycle kills the step.
   assign run = (state == SCAN) && en && (mode == MODE_SCAN);
   assign clr = (state != SCAN);

   scan_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .run   (run),
      .tick  (step)
   );

   assign sel_load = en && (state == MANUAL) && load;

`ifdef SCAN_DECODER_BLANK_EN
   logic blank, blank_nxt;
`endif

   always_comb begin
      state_nxt = IDLE;
      if (en)
         state_nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;

      sel_nxt = sel_cur;
      if (sel_load)
         sel_nxt = sel_in;
      else if (step)
         sel_nxt = sel_cur + 1'b1;

      dec          = '1;
      dec[sel_nxt] = 1'b0;

      out_nxt = (state_nxt == IDLE) ? '1 : dec;
`ifdef SCAN_DECODER_BLANK_EN
      blank_nxt = (state_nxt != IDLE) && (sel_load || step);
      if (blank_nxt)
         out_nxt = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         out_n   <= '1;
         sel_cur <= '0;
         tick    <= 1'b0;
      end else begin
         state   <= state_nxt;
         out_n   <= out_nxt;
         sel_cur <= sel_nxt;
         tick    <= step;
      end
   end

`ifdef SCAN_DECODER_BLANK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         blank <= 1'b0;
      else
         blank <= blank_nxt;
   end

   // The blank flag marks exactly the cycles where out_n is forced high.
   always_ff @(posedge clk) begin
      if (rst_n)
         assert (!blank || (&out_n));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n)
         assert ($countones(~out_n) <= 1);
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=3, PRESCALE=4); honours SCAN_DECODER_BLANK_EN.
module tb_scan_decoder;

   localparam int SEL_W    = 3;
   localparam int PRESCALE = 4;

   logic       clk = 1'b0;
   logic       rst_n, en, mode, load;
   logic [2:0] sel_in;
   logic [7:0] out_n;
   logic [2:0] sel_cur;
   logic       tick;
   logic       mon_on = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(SEL_W), .PRESCALE(PRESCALE)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .load    (load),
      .sel_in  (sel_in),
      .out_n   (out_n),
      .sel_cur (sel_cur),
      .tick    (tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dec(input int i);
      logic [7:0] d;
      d    = 8'hFF;
      d[i] = 1'b0;
      return d;
   endfunction

   // Manual load of v; checks the index and the decoded output after the load.
   task automatic load_v(input string tag, input logic [2:0] v);
      sel_in = v;
      load   = 1'b1;
      cyc();
      load   = 1'b0;
      chk({tag, "_sel"}, sel_cur, v);
`ifdef SCAN_DECODER_BLANK_EN
      chk({tag, "_blank"}, out_n, 8'hFF);
      cyc();
`endif
      chk({tag, "_out"}, out_n, dec(v));
   endtask

   always @(negedge clk)
      if (mon_on && rst_n)
         chk("onehot", ($countones(~out_n) <= 1), 1);

   initial begin
      logic [2:0] prev, nxt;
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0;
      cyc(2);
      chk("rst_out",  out_n,   8'hFF);
      chk("rst_sel",  sel_cur, 0);
      chk("rst_tick", tick,    0);

      rst_n = 1'b1; mon_on = 1'b1;
      cyc();
      chk("idle_out", out_n, 8'hFF);

      en = 1'b1;
      cyc();
      chk("man_entry_out", out_n, 8'hFE);

      load_v("load5", 3'b101);

      sel_in = 3'd2;
      cyc(2);
      chk("noload_sel", sel_cur, 5);
      chk("noload_out", out_n, 8'b1101_1111);

      load_v("load6", 3'd6);

      mode = 1'b1;
      cyc();
      chk("scan_entry_out",  out_n, 8'b1011_1111);
      chk("scan_entry_tick", tick,  0);

      prev = 3'd6;
      for (int s = 0; s < 3; s++) begin
         nxt = prev + 3'd1;
         for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c < 4) chk("scan_notick", tick, 0);
            if (c == 2) chk("scan_hold_out", out_n, dec(prev));
            if (c == 4) begin
               chk("scan_tick", tick, 1);
               chk("scan_sel", sel_cur, nxt);
`ifdef SCAN_DECODER_BLANK_EN
               chk("scan_out", out_n, 8'hFF);
`else
               chk("scan_out", out_n, dec(nxt));
`endif
            end
         end
         prev = nxt;
      end

      cyc(3);
      en = 1'b0;
      cyc();
      chk("tc_drop_tick", tick,    0);
      chk("tc_drop_sel",  sel_cur, 1);
      chk("tc_drop_out",  out_n,   8'hFF);
      cyc();
      chk("idle_hold_sel", sel_cur, 1);

      en = 1'b1;
      cyc();
      chk("rescan_out", out_n, dec(1));
      cyc(12);
      chk("rescan_sel", sel_cur, 4);
      cyc(2);
      rst_n = 1'b0;
      cyc();
      chk("midrst_out",  out_n,   8'hFF);
      chk("midrst_sel",  sel_cur, 0);
      chk("midrst_tick", tick,    0);

      rst_n = 1'b1;
      cyc();
      chk("post_rst_out", out_n, 8'hFE);
      sel_in = 3'd7;
      load   = 1'b1;
      cyc();
      load   = 1'b0;
      chk("scan_load_ign", sel_cur, 0);
      mode = 1'b0;
      cyc();
      chk("scan2man_sel", sel_cur, 0);
      chk("scan2man_out", out_n, 8'hFE);

      load_v("load2", 3'b010);

      en = 1'b0;
      cyc();
      chk("man_off_out", out_n,   8'hFF);
      chk("man_off_sel", sel_cur, 2);

      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
